rbs_shift_scheduler: RTL and testbench
======================================

// Module: rbs_shift_scheduler
// PURPOSE
//  Shares one external 8-bit reversible barrel shifter (left logical, 0..7 per pass)
//  between NREQ requesters. Arbitrates round-robin and accepts one job at a time.
//  Amounts above 7 run as repeated passes, recirculating the shifter output.
//  Returns the result with requester ID on a valid/ready response port.
// PARAMETERS
//  NREQ   2  number of requesters (2..4)
//  AMT_W  5  shift-amount width; max amount 2**AMT_W-1
// PORTS
//  clk        in   1          single clock, rising edge
//  rst_n      in   1          asynchronous, active-low reset
//  req_valid  in   NREQ       per-requester job valid
//  req_data   in   8*NREQ     operand, requester i at [8i+7:8i]
//  req_amt    in   AMT_W*NREQ shift amount, requester i at [AMT_W*i+:AMT_W]
//  req_ready  out  NREQ       one-hot or zero; job accepted when valid&ready
//  sh_x       out  8          operand to shared shifter X
//  sh_y       out  3          pass amount to shifter Y
//  sh_z       in   8          shifter result Z (combinational, same cycle)
//  rsp_valid  out  1          result available
//  rsp_data   out  8          shifted result
//  rsp_id     out  clog2(NREQ) granted requester index (min width 1)
//  rsp_ready  in   1          consumer accepts when rsp_valid&rsp_ready
//  busy       out  1          1 in any state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, work=0, remain=0, rsp_valid=0, rsp_data=0,
//   rsp_id=0, sh_x=0, sh_y=0, req_ready=0, busy=0.
//  FSM: IDLE -> SHIFT -> DONE -> IDLE.
//  IDLE: grant = first valid requester searching from rr_ptr upward (wrap).
//   req_ready[grant]=1 combinationally, only in IDLE. On accept: work<=req_data,
//   remain<=req_amt, id<=grant, rr_ptr<=grant+1 (mod NREQ), go to SHIFT.
//   No valid requests: stay in IDLE, req_ready=0.
//  SHIFT: one pass per cycle. sh_x=work, sh_y=min(remain,7).
//   work<=sh_z, remain<=remain-sh_y.
//   Move to DONE when remain-sh_y==0. Amount 0 still runs one pass with sh_y=0.
//   Pass count = max(1, ceil(amt/7)). Amount 31 -> 5 passes (7,7,7,7,3).
//  DONE: rsp_valid=1, rsp_data/rsp_id held stable until rsp_ready.
//   On handshake go to IDLE. No new grant in that cycle: accept-to-accept
//   minimum is passes+2 cycles.
//  Outside SHIFT: sh_x=0, sh_y=0, so the shared shifter sees quiet inputs.
//  Result: (operand << amt) truncated to 8 bits. Any amt>=8 yields 8'h00.
//  A requester dropping valid before grant loses nothing: no job is latched.
//  req_data/req_amt are sampled only on the accept edge.
//  rsp_ready held high in DONE: single-cycle response.
//  rsp_ready low: unbounded stall in DONE, with no further grants.
//  Async reset mid-job discards the job immediately; no response is produced.
// STRUCTURE
//  Shared package rbs_pkg: state enum (IDLE/SHIFT/DONE) and constant
//   RBS_MAX_PASS=3'd7; pass amount is 3 bits, matching shifter Y.
//  One sub-module: rbs_rr_arbiter (req vector, rr_ptr -> one-hot grant + index).
//  The shifter itself is instantiated beside this block, not inside it.
// TESTING
//  1. Reset mid-SHIFT (assert rst_n=0 during pass 2 of amt=20)
//     -> all outputs at reset values, next job starts clean.
//  2. Single req0: data 8'hA5, amt 3 -> 1 pass (sh_y=3), rsp_data 8'h28, rsp_id 0,
//     rsp_valid 2 cycles after accept.
//  3. req1: data 8'h01, amt 7 -> 1 pass, rsp 8'h80; amt 0 -> 1 pass, rsp 8'h01.
//  4. req0: data 8'hFF, amt 9 -> passes sh_y=7 then 2, rsp 8'h00;
//     amt 31 -> 5 passes, rsp 8'h00.
//  5. Both valid continuously, 4 jobs -> grants alternate 0,1,0,1, rsp_id matches,
//     req_ready never two-hot.
//  6. rsp_ready low 5 cycles in DONE -> rsp_data/id stable, req_ready=0,
//     sh_y=0 throughout.

Source files
------------

// File: rtl/rbs_pkg.sv
// rbs_pkg -- shared types and constants for the shared barrel-shifter scheduler.
//   rbs_state_e   : scheduler FSM states
//   RBS_MAX_PASS  : largest amount the external shifter handles in one pass
//   rbs_id_width  : width of a requester index (never below 1 bit)
package rbs_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } rbs_state_e;

  localparam logic [2:0] RBS_MAX_PASS = 3'd7;

  function automatic int rbs_id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rbs_rr_arbiter.sv
// rbs_rr_arbiter -- combinational round-robin pick.
//   req       in   NREQ   request vector
//   rr_ptr    in   ID_W   index searched first; search wraps upward
//   grant_oh  out  NREQ   one-hot grant (zero when no request)
//   grant_idx out  ID_W   index of the granted requester
//   grant_any out  1      at least one request present
module rbs_rr_arbiter
  import rbs_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int ID_W = rbs_id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] rr_ptr,
  output logic [NREQ-1:0] grant_oh,
  output logic [ID_W-1:0] grant_idx,
  output logic            grant_any
);

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    // k walks the search order (rr_ptr first), j matches the physical requester
    for (int k = 0; k < NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!grant_any && req[j] && (j == ((int'(rr_ptr) + k) % NREQ))) begin
          grant_any   = 1'b1;
          grant_oh[j] = 1'b1;
          grant_idx   = ID_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/rbs_shift_scheduler.sv
// rbs_shift_scheduler -- time-shares one external 8-bit left barrel shifter
// (0..7 per pass) among NREQ requesters. One job in flight; amounts above 7
// recirculate the shifter output over several passes.
//   clk, rst_n             clock, async active-low reset
//   req_valid/ready        per-requester job handshake (ready one-hot or zero)
//   req_data, req_amt      packed per-requester operand and shift amount
//   sh_x, sh_y / sh_z      operand and pass amount to the shifter / its result
//   rsp_valid/ready        result handshake; rsp_data, rsp_id carry the result
//   busy                   high whenever a job is held
//
// state | meaning
// IDLE  | waiting for a request; grants one job per visit
// SHIFT | one shifter pass per cycle until the amount is used up
// DONE  | result presented, held until rsp_ready
module rbs_shift_scheduler
  import rbs_pkg::*;
#(
  parameter  int NREQ  = 2,
  parameter  int AMT_W = 5,
  localparam int ID_W  = rbs_id_width(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [8*NREQ-1:0]     req_data,
  input  logic [AMT_W*NREQ-1:0] req_amt,
  output logic [NREQ-1:0]       req_ready,
  output logic [7:0]            sh_x,
  output logic [2:0]            sh_y,
  input  logic [7:0]            sh_z,
  output logic                  rsp_valid,
  output logic [7:0]            rsp_data,
  output logic [ID_W-1:0]       rsp_id,
  input  logic                  rsp_ready,
  output logic                  busy
);

  rbs_state_e       state;
  logic [ID_W-1:0]  rr_ptr;
  logic [7:0]       work;
  logic [AMT_W-1:0] remain;

  logic [NREQ-1:0]  grant_oh;
  logic [ID_W-1:0]  grant_idx;
  logic             grant_any;
  logic [ID_W-1:0]  ptr_next;
  logic [2:0]       pass_amt;
  logic [AMT_W-1:0] remain_next;

  rbs_rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // remain is a down-counter; each pass consumes at most RBS_MAX_PASS of it
  assign pass_amt    = (remain > AMT_W'(RBS_MAX_PASS)) ? RBS_MAX_PASS : remain[2:0];
  assign remain_next = remain - AMT_W'(pass_amt);
  assign ptr_next    = (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + ID_W'(1);

  // shifter inputs held at zero outside SHIFT so the shared block sees no toggling
  assign sh_x      = (state == SHIFT) ? work : 8'h00;
  assign sh_y      = (state == SHIFT) ? pass_amt : 3'd0;
  assign req_ready = (state == IDLE) ? grant_oh : '0;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      work      <= '0;
      remain    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            work   <= req_data[8*grant_idx +: 8];
            remain <= req_amt[AMT_W*grant_idx +: AMT_W];
            rsp_id <= grant_idx;
            rr_ptr <= ptr_next;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          // amount 0 lands here too and leaves after a single zero-shift pass
          work   <= sh_z;
          remain <= remain_next;
          if (remain_next == '0) begin
            rsp_data  <= sh_z;
            rsp_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rbs_shift_scheduler.sv
module tb_rbs_shift_scheduler;

  localparam int NREQ  = 2;
  localparam int AMT_W = 5;
  localparam int ID_W  = 1;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req_valid;
  logic [8*NREQ-1:0]     req_data;
  logic [AMT_W*NREQ-1:0] req_amt;
  logic [NREQ-1:0]       req_ready;
  logic [7:0]            sh_x;
  logic [2:0]            sh_y;
  logic [7:0]            sh_z;
  logic                  rsp_valid;
  logic [7:0]            rsp_data;
  logic [ID_W-1:0]       rsp_id;
  logic                  rsp_ready;
  logic                  busy;

  rbs_shift_scheduler #(.NREQ(NREQ), .AMT_W(AMT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_amt   (req_amt),
    .req_ready (req_ready),
    .sh_x      (sh_x),
    .sh_y      (sh_y),
    .sh_z      (sh_z),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // the external shared shifter
  assign sh_z = sh_x << sh_y;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  int  sb_data[$];
  int  sb_id[$];
  int  pass_q[$];
  int  grant_log[$];
  int  exp_work;
  bit  model_busy = 0;
  int  model_ptr = 0;
  bit  expect_done = 0;
  bit  hold = 0;
  int  hold_data, hold_id;
  int  stall_cnt = 0;
  int  last_rsp_data = -1;
  int  last_rsp_id = -1;
  logic [NREQ-1:0] acc_vec = '0;

  logic [NREQ-1:0] m_exp_rr;
  int m_pred, m_p, m_id, m_data, m_amt, m_rem;
  bit m_found;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb_data.delete();
      sb_id.delete();
      pass_q.delete();
      model_busy  = 0;
      model_ptr   = 0;
      expect_done = 0;
      hold        = 0;
      acc_vec     = '0;
    end else begin
      chk("busy", busy, model_busy);
      chk("req_ready_onehot0", $onehot0(req_ready), 1);

      // round-robin: first valid requester from the pointer, only when idle
      m_exp_rr = '0;
      m_found  = 0;
      if (!model_busy) begin
        for (int k = 0; k < NREQ; k++) begin
          m_pred = (model_ptr + k) % NREQ;
          if (!m_found && req_valid[m_pred]) begin
            m_exp_rr = NREQ'(1 << m_pred);
            m_found  = 1;
          end
        end
      end
      chk("req_ready", req_ready, m_exp_rr);
      acc_vec = req_valid & req_ready;

      if (pass_q.size() > 0) begin
        m_p = pass_q.pop_front();
        chk("sh_y_pass", sh_y, m_p);
        chk("sh_x_pass", sh_x, exp_work);
        chk("rsp_valid_in_shift", rsp_valid, 0);
        exp_work = (exp_work << m_p) & 255;
        if (pass_q.size() == 0) expect_done = 1;
      end else begin
        chk("sh_quiet", {sh_x, sh_y}, 0);
        if (expect_done) begin
          chk("rsp_latency", rsp_valid, 1);
          expect_done = 0;
        end
      end

      if (rsp_valid) begin
        if (hold) begin
          chk("rsp_data_stable", rsp_data, hold_data);
          chk("rsp_id_stable", rsp_id, hold_id);
        end
        if (rsp_ready) begin
          if (sb_data.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected: got data 0x%0h id %0d expected no response", rsp_data, rsp_id);
          end else begin
            chk("rsp_data", rsp_data, sb_data.pop_front());
            chk("rsp_id", rsp_id, sb_id.pop_front());
          end
          last_rsp_data = rsp_data;
          last_rsp_id   = rsp_id;
          model_busy    = 0;
          hold          = 0;
        end else begin
          hold      = 1;
          hold_data = rsp_data;
          hold_id   = rsp_id;
          stall_cnt++;
        end
      end else begin
        hold = 0;
      end

      if (acc_vec != '0) begin
        m_id = 0;
        for (int i = 0; i < NREQ; i++) if (acc_vec[i]) m_id = i;
        m_data = int'(req_data[8*m_id +: 8]);
        m_amt  = int'(req_amt[AMT_W*m_id +: AMT_W]);
        // passes: min(remaining, 7) until used up; amount 0 is a single zero pass
        m_rem = m_amt;
        if (m_rem == 0) pass_q.push_back(0);
        while (m_rem > 0) begin
          m_p = (m_rem > 7) ? 7 : m_rem;
          pass_q.push_back(m_p);
          m_rem -= m_p;
        end
        exp_work = m_data;
        sb_data.push_back((m_amt >= 8) ? 0 : ((m_data << m_amt) & 255));
        sb_id.push_back(m_id);
        grant_log.push_back(m_id);
        model_busy = 1;
        model_ptr  = (m_id + 1) % NREQ;
      end
    end
  end

  // ---------------- response-side driver ----------------
  bit rsp_force_low = 0;
  bit rsp_random = 0;

  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rsp_ready = rsp_force_low ? 1'b0 : (rsp_random ? ($urandom_range(1) == 1) : 1'b1);
    end
  end

  // ---------------- request-side driver ----------------
  typedef struct {
    int data;
    int amt;
  } job_t;

  job_t jq[NREQ][$];
  bit   gaps = 0;

  task automatic run_jobs(input int max_cyc);
    int  n = 0;
    bit  done = 0;
    bit  empty;
    job_t j;
    while (!done) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && acc_vec[i]) begin
          req_valid[i] = 1'b0;
          j = jq[i].pop_front();
        end else if (req_valid[i] && gaps && $urandom_range(7) == 0) begin
          req_valid[i] = 1'b0;   // withdraw; job stays queued
        end
        if (!req_valid[i] && jq[i].size() > 0 && (!gaps || $urandom_range(2) != 0)) begin
          req_data[8*i +: 8]         = 8'(jq[i][0].data);
          req_amt[AMT_W*i +: AMT_W]  = AMT_W'(jq[i][0].amt);
          req_valid[i]               = 1'b1;
        end
      end
      n++;
      empty = 1;
      for (int i = 0; i < NREQ; i++) if (jq[i].size() > 0) empty = 0;
      done = empty && (req_valid == '0) && !model_busy;
      if (!done && n > max_cyc) begin
        checks++;
        errors++;
        $display("FAIL run_jobs_timeout: got %0d cycles expected completion within %0d", n, max_cyc);
        done = 1;
      end
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"},  rsp_data, 0);
    chk({tag, "_rsp_id"},    rsp_id, 0);
    chk({tag, "_sh_x"},      sh_x, 0);
    chk({tag, "_sh_y"},      sh_y, 0);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_busy"},      busy, 0);
  endtask

  task automatic push_job(input int r, input int d, input int a);
    job_t j;
    j.data = d;
    j.amt  = a;
    jq[r].push_back(j);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    req_valid = '0;
    req_data  = '0;
    req_amt   = '0;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("por");
    @(negedge clk);
    rst_n = 1'b1;

    // reset during pass 2 of amount 20
    @(posedge clk);
    #1;
    req_data[7:0] = 8'h5A;
    req_amt[4:0]  = 5'd20;
    req_valid[0]  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(req_valid[0] && req_ready[0]) && n < 50);
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL t1_accept_timeout: got no grant expected grant within 50 cycles");
    end
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    @(posedge clk);
    #2;
    chk("t1_pass2_sh_y", sh_y, 7);
    chk("t1_pass2_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk_reset("midjob");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // single job on requester 0
    push_job(0, 'hA5, 3);
    run_jobs(200);
    chk("t2_rsp_data", last_rsp_data, 'h28);
    chk("t2_rsp_id", last_rsp_id, 0);

    // multi-pass on requester 0
    push_job(0, 'hFF, 9);
    run_jobs(200);
    chk("t4_amt9_rsp", last_rsp_data, 'h00);
    push_job(0, 'hFF, 31);
    run_jobs(200);
    chk("t4_amt31_rsp", last_rsp_data, 'h00);

    // requester 1 boundary amounts
    push_job(1, 'h01, 7);
    run_jobs(200);
    chk("t3_amt7_rsp", last_rsp_data, 'h80);
    chk("t3_amt7_id", last_rsp_id, 1);
    push_job(1, 'h01, 0);
    run_jobs(200);
    chk("t3_amt0_rsp", last_rsp_data, 'h01);

    // both requesters continuously valid
    grant_log.delete();
    for (int k = 0; k < 2; k++) begin
      push_job(0, $urandom_range(255), $urandom_range(31));
      push_job(1, $urandom_range(255), $urandom_range(31));
    end
    run_jobs(400);
    chk("t5_grant_count", grant_log.size(), 4);
    for (int k = 0; k < 4 && k < grant_log.size(); k++)
      chk($sformatf("t5_grant%0d", k), grant_log[k], k % 2);

    // consumer stalls in DONE while the other requester waits
    rsp_force_low = 1;
    @(posedge clk);
    @(posedge clk);
    #1;
    push_job(0, 'h3C, 2);
    push_job(1, 'h11, 1);
    fork
      run_jobs(400);
      begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!rsp_valid && n < 50);
        stall_cnt = 0;
        repeat (5) @(negedge clk);
        chk("t6_stall_cycles_ge5", (stall_cnt >= 5) ? 1 : 0, 1);
        chk("t6_req1_waiting", req_valid[1], 1);
        chk("t6_rsp_id_during_stall", rsp_id, 0);
        rsp_force_low = 0;
      end
    join
    chk("t6_last_rsp", last_rsp_data, 'h22);

    // randomized mix
    rsp_random = 1;
    gaps = 1;
    for (int k = 0; k < 40; k++) begin
      int amt;
      int bnd[6];
      bnd = '{0, 7, 8, 14, 15, 31};
      amt = ($urandom_range(2) == 0) ? bnd[$urandom_range(5)] : $urandom_range(31);
      push_job($urandom_range(NREQ - 1), $urandom_range(255), amt);
    end
    run_jobs(5000);
    rsp_random = 0;
    gaps = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("final_sb_empty", sb_data.size(), 0);
    chk("final_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
